// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, requester count and the fixed requester IDs.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NREQ = 3;

    // grant index / round-robin pointer width (NREQ is at most 4)
    localparam int PW = 2;

    localparam logic [PW-1:0] REQ_ALU = 2'd0;
    localparam logic [PW-1:0] REQ_LSU = 2'd1;
    localparam logic [PW-1:0] REQ_CSR = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first valid requester at or above
// the pointer (wrapping), its one-hot grant, index and the next pointer.
// Ports: i_valid, i_ptr in; o_grant, o_idx, o_next_ptr out.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic [PW-1:0]   o_next_ptr
);

    logic          w_found;
    logic [PW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_valid[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

    // only consumed by the top when a transfer happens
    assign o_next_ptr = (o_idx == PW'(NREQ - 1)) ? '0 : o_idx + 1'b1;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin among NREQ requesters,
// registered write port (WE3/A3/WD3/grant_id) and decode forwarding check.
// Ports: clk, rst, flush, req_valid/addr/data in, req_ready out,
// WE3/A3/WD3/grant_id out, chk_addr1/2 in, fwd_hit1/2 and fwd_data out.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 WE3,
    output logic [AW-1:0]        A3,
    output logic [XLEN-1:0]      WD3,
    output logic [1:0]           grant_id,
    input  logic [AW-1:0]        chk_addr1,
    input  logic [AW-1:0]        chk_addr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [XLEN-1:0]      fwd_data
);

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_next_ptr;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    logic [PW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_a3;
    logic [XLEN-1:0] r_wd;
    logic [PW-1:0]   r_gid;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .i_valid   (req_valid),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_next_ptr(w_next_ptr)
    );

    // reset and flush suppress acceptance in the same cycle
    assign req_ready = (rst || flush) ? '0 : w_grant;
    assign w_xfer    = |(req_valid & req_ready);
    assign w_addr    = req_addr[w_idx*AW +: AW];
    assign w_data    = req_data[w_idx*XLEN +: XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_a3  <= '0;
            r_wd  <= '0;
            r_gid <= REQ_ALU;
            r_ptr <= '0;
        end else if (w_xfer) begin
            // x0 writes are consumed but never reach the file
            r_we  <= (w_addr != '0);
            r_a3  <= w_addr;
            r_wd  <= w_data;
            r_gid <= w_idx;
            r_ptr <= w_next_ptr;
        end else begin
            r_we  <= 1'b0;
        end
    end

    assign WE3      = r_we;
    assign A3       = r_a3;
    assign WD3      = r_wd;
    assign grant_id = r_gid;

    assign fwd_hit1 = r_we & (r_a3 == chk_addr1) & (chk_addr1 != '0);
    assign fwd_hit2 = r_we & (r_a3 == chk_addr2) & (chk_addr2 != '0);
    assign fwd_data = r_wd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, forwarding
// sequence, then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int AW = 5;
    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h0000_1234;
    localparam logic [31:0] D2 = 32'hCAFE_0002;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*XL-1:0] req_data;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [XL-1:0] WD3;
    logic [1:0]    grant_id;
    logic [AW-1:0] chk_addr1, chk_addr2;
    logic          fwd_hit1, fwd_hit2;
    logic [XL-1:0] fwd_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(N), .XLEN(XL), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready),
        .WE3(WE3), .A3(A3), .WD3(WD3), .grant_id(grant_id),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  v;
        logic        fl;
        logic        rs;
        logic [4:0]  a0, a1, a2;
        logic [2:0]  er;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [1:0]  eg;
    } vec_t;

    vec_t tbl[16];

    // behavioural model state
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    int          m_gid;
    bit          pend[N];
    int          waitc[N];

    initial begin
        tbl[0]  = '{3'b001, 0, 0, 5, 0, 0, 3'b001, 1, 5, D0, 0};
        tbl[1]  = '{3'b000, 0, 0, 5, 0, 0, 3'b000, 0, 5, D0, 0};
        tbl[2]  = '{3'b111, 0, 1, 1, 2, 3, 3'b000, 0, 0, 0, 0};
        tbl[3]  = '{3'b111, 0, 0, 1, 2, 3, 3'b001, 1, 1, D0, 0};
        tbl[4]  = '{3'b111, 0, 0, 1, 2, 3, 3'b010, 1, 2, D1, 1};
        tbl[5]  = '{3'b111, 0, 0, 1, 2, 3, 3'b100, 1, 3, D2, 2};
        tbl[6]  = '{3'b111, 0, 0, 1, 2, 3, 3'b001, 1, 1, D0, 0};
        tbl[7]  = '{3'b010, 0, 0, 1, 0, 3, 3'b010, 0, 0, D1, 1};
        tbl[8]  = '{3'b111, 0, 0, 1, 2, 3, 3'b100, 1, 3, D2, 2};
        tbl[9]  = '{3'b111, 1, 0, 1, 2, 3, 3'b000, 0, 3, D2, 2};
        tbl[10] = '{3'b111, 0, 0, 1, 2, 3, 3'b001, 1, 1, D0, 0};
        tbl[11] = '{3'b101, 0, 0, 1, 2, 3, 3'b100, 1, 3, D2, 2};
        tbl[12] = '{3'b100, 1, 1, 1, 2, 3, 3'b000, 0, 0, 0, 0};
        tbl[13] = '{3'b101, 0, 0, 1, 2, 3, 3'b001, 1, 1, D0, 0};
        tbl[14] = '{3'b011, 0, 0, 9, 9, 3, 3'b010, 1, 9, D1, 1};
        tbl[15] = '{3'b001, 0, 0, 9, 9, 3, 3'b001, 1, 9, D0, 0};

        rst = 1'b1; flush = 1'b0; req_valid = 3'b111;
        req_addr = '0; req_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        #1;
        check("rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd", WD3, 0);
        check("rst_gid", grant_id, 0);

        rst = 1'b0;
        req_data = {D2, D1, D0};
        foreach (tbl[r]) begin
            req_valid = tbl[r].v;
            flush     = tbl[r].fl;
            rst       = tbl[r].rs;
            req_addr  = {tbl[r].a2, tbl[r].a1, tbl[r].a0};
            #1;
            check($sformatf("v%0d_ready", r), req_ready, tbl[r].er);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", r), WE3, tbl[r].ew);
            check($sformatf("v%0d_a3", r), A3, tbl[r].ea);
            check($sformatf("v%0d_wd", r), WD3, tbl[r].ed);
            check($sformatf("v%0d_gid", r), grant_id, tbl[r].eg);
        end
        rst = 1'b0; flush = 1'b0;

        // forwarding: write to x7 from requester 0 (pointer is 1 here)
        req_valid = 3'b001;
        req_addr  = {5'd3, 5'd9, 5'd7};
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        #1;
        check("fwd_hit1", fwd_hit1, 1);
        check("fwd_hit2_x0", fwd_hit2, 0);
        check("fwd_data", fwd_data, D0);
        chk_addr2 = 5'd7; chk_addr1 = 5'd6;
        #1;
        check("fwd_hit2", fwd_hit2, 1);
        check("fwd_hit1_miss", fwd_hit1, 0);
        @(posedge clk);
        #1;
        chk_addr1 = 5'd7;
        #1;
        check("fwd_idle", fwd_hit1, 0);
        @(posedge clk);
        #1;

        // randomized phase, model starts from known state
        m_ptr = 1; m_we = 0; m_a3 = 5'd7; m_wd = D0; m_gid = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; waitc[i] = 0;
        end
        for (int c = 0; c < 500; c++) begin
            int win;
            logic [N-1:0] er;
            rst   = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1; waitc[i] = 0;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                    req_data[i*XL +: XL] = $urandom;
                end
                req_valid[i] = pend[i];
            end
            chk_addr1 = AW'($urandom_range(0, 3));
            chk_addr2 = AW'($urandom_range(0, 3));

            win = -1;
            if (!rst && !flush)
                for (int k = 0; k < N; k++)
                    if (win < 0 && pend[(m_ptr + k) % N])
                        win = (m_ptr + k) % N;
            er = (win >= 0) ? N'(1 << win) : '0;
            #1;
            check("rnd_ready", req_ready, er);
            check("rnd_fwd1", fwd_hit1,
                  m_we && m_a3 == chk_addr1 && chk_addr1 != 0);
            check("rnd_fwd2", fwd_hit2,
                  m_we && m_a3 == chk_addr2 && chk_addr2 != 0);
            check("rnd_fwdd", fwd_data, m_wd);

            for (int i = 0; i < N; i++) begin
                if (rst || flush) waitc[i] = 0;
                else if (pend[i]) waitc[i]++;
            end
            if (rst) begin
                m_we = 0; m_a3 = 0; m_wd = 0; m_gid = 0; m_ptr = 0;
            end else if (win >= 0) begin
                check("rnd_fair", waitc[win] <= N, 1);
                m_a3  = req_addr[win*AW +: AW];
                m_wd  = req_data[win*XL +: XL];
                m_we  = (m_a3 != 0);
                m_gid = win;
                m_ptr = (win + 1) % N;
                pend[win] = 0;
            end else begin
                m_we = 0;
            end

            @(posedge clk);
            #1;
            check("rnd_we", WE3, m_we);
            check("rnd_a3", A3, m_a3);
            check("rnd_wd", WD3, m_wd);
            check("rnd_gid", grant_id, m_gid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
